// File: rtl/tmds_align_ctrl.sv
// tmds_align_ctrl
// Word-alignment controller for the three TMDS receive channels. It watches
// each channel's 10-bit de-serialized word for control tokens. Until a channel
// sees enough tokens in one search window, it issues single-cycle bitslip
// pulses back to the de-serializer. It reports per-channel and aggregate lock.
//
// Ports
//   i_pixclk        : pixel clock, the only clock
//   i_rst           : asynchronous active-high reset
//   i_enable        : level; while low every channel is held in SEARCH
//   i_encoded_blue  : channel 0 word (10 bits)
//   i_encoded_green : channel 1 word (10 bits)
//   i_encoded_red   : channel 2 word (10 bits)
//   o_bitslip[2:0]  : one-cycle bitslip request per channel (bit0 = blue)
//   o_locked[2:0]   : per-channel lock
//   o_all_locked    : registered AND of o_locked
//   o_slip_cnt[11:0]: current slip position 0..9, 4 bits per channel
//   o_align_err[2:0]: sticky flag, set when a channel wraps through all
//                     10 positions without locking, cleared when it locks
//
// Optional feature: define TMDS_ALIGN_RELOCK_EN to drop lock after
// LOSS_CYCLES consecutive token-free cycles in LOCKED. Without the macro,
// LOCKED is left only on reset or when i_enable goes low.
module tmds_align_ctrl #(
  parameter int WINDOW_CYCLES = 4096,
  parameter int TOKEN_MIN     = 16,
  parameter int SLIP_WAIT     = 8,
  parameter int LOSS_CYCLES   = 65536
) (
  input  logic        i_pixclk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [9:0]  i_encoded_blue,
  input  logic [9:0]  i_encoded_green,
  input  logic [9:0]  i_encoded_red,
  output logic [2:0]  o_bitslip,
  output logic [2:0]  o_locked,
  output logic        o_all_locked,
  output logic [11:0] o_slip_cnt,
  output logic [2:0]  o_align_err
);

  // Each counter only ever holds 0..PARAM-1, so $clog2(PARAM) bits suffice.
  localparam int WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int TOK_W  = (TOKEN_MIN > 1) ? $clog2(TOKEN_MIN) : 1;
  localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
`ifdef TMDS_ALIGN_RELOCK_EN
  localparam int LOSS_W = (LOSS_CYCLES > 1) ? $clog2(LOSS_CYCLES) : 1;
`endif

  typedef enum logic [1:0] {ST_SEARCH, ST_SLIP, ST_WAIT, ST_LOCKED} state_t;

  function automatic logic is_token(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  logic [9:0] word [3];
  logic [2:0] locked;
  logic       all_locked_q;

  assign word[0] = i_encoded_blue;
  assign word[1] = i_encoded_green;
  assign word[2] = i_encoded_red;

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    state_t             state_q, state_d;
    logic               tok_q, tok_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [TOK_W-1:0]   tok_cnt_q, tok_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]         slip_cnt_q, slip_cnt_d;
    logic               err_q, err_d;
`ifdef TMDS_ALIGN_RELOCK_EN
    logic [LOSS_W-1:0]  loss_cnt_q, loss_cnt_d;
`endif

    always_ff @(posedge i_pixclk or posedge i_rst) begin
      if (i_rst) begin
        state_q    <= ST_SEARCH;
        tok_q      <= 1'b0;
        win_cnt_q  <= '0;
        tok_cnt_q  <= '0;
        wait_cnt_q <= '0;
        slip_cnt_q <= '0;
        err_q      <= 1'b0;
`ifdef TMDS_ALIGN_RELOCK_EN
        loss_cnt_q <= '0;
`endif
      end else begin
        state_q    <= state_d;
        tok_q      <= tok_d;
        win_cnt_q  <= win_cnt_d;
        tok_cnt_q  <= tok_cnt_d;
        wait_cnt_q <= wait_cnt_d;
        slip_cnt_q <= slip_cnt_d;
        err_q      <= err_d;
`ifdef TMDS_ALIGN_RELOCK_EN
        loss_cnt_q <= loss_cnt_d;
`endif
      end
    end

    always_comb begin
      tok_d      = is_token(word[gi]);
      state_d    = state_q;
      win_cnt_d  = win_cnt_q;
      tok_cnt_d  = tok_cnt_q;
      wait_cnt_d = wait_cnt_q;
      slip_cnt_d = slip_cnt_q;
      err_d      = err_q;
`ifdef TMDS_ALIGN_RELOCK_EN
      loss_cnt_d = loss_cnt_q;
`endif
      if (!i_enable) begin
        // Slip position and error flag survive a disable; the search restarts.
        state_d    = ST_SEARCH;
        win_cnt_d  = '0;
        tok_cnt_d  = '0;
        wait_cnt_d = '0;
`ifdef TMDS_ALIGN_RELOCK_EN
        loss_cnt_d = '0;
`endif
      end else begin
        case (state_q)
          ST_SEARCH: begin
            // Lock is tested on the token that would make the count reach
            // TOKEN_MIN, so tok_cnt never needs to hold TOKEN_MIN itself.
            // Lock wins over window expiry in the same cycle.
            if (tok_q && (tok_cnt_q == TOK_W'(TOKEN_MIN - 1))) begin
              state_d   = ST_LOCKED;
              err_d     = 1'b0;
              win_cnt_d = '0;
              tok_cnt_d = '0;
`ifdef TMDS_ALIGN_RELOCK_EN
              loss_cnt_d = '0;
`endif
            end else if (win_cnt_q == WIN_W'(WINDOW_CYCLES - 1)) begin
              state_d   = ST_SLIP;
              win_cnt_d = '0;
              tok_cnt_d = '0;
            end else begin
              win_cnt_d = win_cnt_q + WIN_W'(1);
              if (tok_q) tok_cnt_d = tok_cnt_q + TOK_W'(1);
            end
          end
          ST_SLIP: begin
            state_d    = ST_WAIT;
            wait_cnt_d = '0;
            if (slip_cnt_q == 4'd9) begin
              slip_cnt_d = 4'd0;
              err_d      = 1'b1;
            end else begin
              slip_cnt_d = slip_cnt_q + 4'd1;
            end
          end
          ST_WAIT: begin
            // Tokens seen here come from a word boundary still settling.
            if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
              state_d   = ST_SEARCH;
              win_cnt_d = '0;
              tok_cnt_d = '0;
            end else begin
              wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
          end
          ST_LOCKED: begin
`ifdef TMDS_ALIGN_RELOCK_EN
            if (tok_q) begin
              loss_cnt_d = '0;
            end else if (loss_cnt_q == LOSS_W'(LOSS_CYCLES - 1)) begin
              state_d    = ST_SEARCH;
              loss_cnt_d = '0;
              win_cnt_d  = '0;
              tok_cnt_d  = '0;
            end else begin
              loss_cnt_d = loss_cnt_q + LOSS_W'(1);
            end
`endif
          end
          default: state_d = ST_SEARCH;
        endcase
      end
    end

    // Decoded straight from the state register so an async reset clears
    // the bitslip request without waiting for a clock edge.
    assign o_bitslip[gi]          = (state_q == ST_SLIP);
    assign locked[gi]             = (state_q == ST_LOCKED);
    assign o_slip_cnt[4*gi +: 4]  = slip_cnt_q;
    assign o_align_err[gi]        = err_q;
  end

  always_ff @(posedge i_pixclk or posedge i_rst) begin
    if (i_rst) all_locked_q <= 1'b0;
    else       all_locked_q <= &locked;
  end

  assign o_locked     = locked;
  assign o_all_locked = all_locked_q;

endmodule

// File: tb/tb_tmds_align_ctrl.sv
module tb_tmds_align_ctrl;
  localparam int W     = 64;
  localparam int TM    = 16;
  localparam int SW    = 8;
  localparam int LC    = 100;
  localparam int PER   = W + 1 + SW;   // slip period, 73
  localparam int NEVER = 1000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [9:0]  enc [3];
  logic [2:0]  o_bitslip, o_locked, o_align_err;
  logic        o_all_locked;
  logic [11:0] o_slip_cnt;

  always #5 clk = ~clk;

  tmds_align_ctrl #(
    .WINDOW_CYCLES(W), .TOKEN_MIN(TM), .SLIP_WAIT(SW), .LOSS_CYCLES(LC)
  ) dut (
    .i_pixclk(clk), .i_rst(rst), .i_enable(en),
    .i_encoded_blue(enc[0]), .i_encoded_green(enc[1]), .i_encoded_red(enc[2]),
    .o_bitslip(o_bitslip), .o_locked(o_locked), .o_all_locked(o_all_locked),
    .o_slip_cnt(o_slip_cnt), .o_align_err(o_align_err)
  );

  int errors = 0;
  int checks = 0;

  // Bench-side channel model and observations
  int         cyc;
  int         rot [3];
  logic [9:0] tw [3];
  int         tfrom [3];
  int         tuntil [3];
  int         slips [3];
  int         lock_cyc [3];
  int         drop_cyc [3];
  int         all_cyc;
  logic [2:0] err_seen;
  int         exp_q [3][$];   // scoreboard: expected bitslip cycles

  typedef struct packed {
    logic [2:0][3:0]  rot;
    logic [2:0][9:0]  tw;
    logic [2:0][19:0] tfrom;
    logic [15:0]      run;
    logic [2:0][3:0]  nslip;
    logic [2:0][15:0] lock;
    logic [15:0]      all_lock;
    logic [11:0]      slip_cnt;
    logic [2:0]       err_seen;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
    logic [19:0] t;
    t = {w, w} << n;
    return t[19:10];
  endfunction

  function automatic vec_t mk(input int r0, r1, r2, input logic [9:0] t0, t1, t2,
                              input int f0, f1, f2, input int run,
                              input int n0, n1, n2, input int l0, l1, l2,
                              input int al, input logic [11:0] sc, input logic [2:0] es);
    vec_t v;
    v.rot[0] = 4'(r0); v.rot[1] = 4'(r1); v.rot[2] = 4'(r2);
    v.tw[0] = t0; v.tw[1] = t1; v.tw[2] = t2;
    v.tfrom[0] = 20'(f0); v.tfrom[1] = 20'(f1); v.tfrom[2] = 20'(f2);
    v.run = 16'(run);
    v.nslip[0] = 4'(n0); v.nslip[1] = 4'(n1); v.nslip[2] = 4'(n2);
    v.lock[0] = 16'(l0); v.lock[1] = 16'(l1); v.lock[2] = 16'(l2);
    v.all_lock = 16'(al);
    v.slip_cnt = sc;
    v.err_seen = es;
    return v;
  endfunction

  // Observe outputs for the current cycle, scoreboard bitslips, drive the
  // next words (de-serializer model de-rotates by one per bitslip), advance.
  task automatic step();
    int e;
    int eff;
    for (int ch = 0; ch < 3; ch++) begin
      if (o_bitslip[ch]) begin
        slips[ch]++;
        if (exp_q[ch].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_slip ch%0d: got pulse at cycle %0d expected none", ch, cyc);
        end else begin
          e = exp_q[ch].pop_front();
          chk($sformatf("slip_time_ch%0d", ch), cyc, e);
        end
      end
      if (o_locked[ch] && lock_cyc[ch] < 0) lock_cyc[ch] = cyc;
      if (!o_locked[ch] && lock_cyc[ch] >= 0 && drop_cyc[ch] < 0) drop_cyc[ch] = cyc;
      if (o_align_err[ch]) err_seen[ch] = 1'b1;
      eff = ((rot[ch] - slips[ch]) % 10 + 10) % 10;
      if (cyc >= tfrom[ch] && cyc < tuntil[ch]) enc[ch] = rotl(tw[ch], eff);
      else enc[ch] = 10'h000;
    end
    if (o_all_locked && all_cyc < 0) all_cyc = cyc;
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    for (int ch = 0; ch < 3; ch++) begin
      enc[ch] = 10'h000; rot[ch] = 0; tw[ch] = 10'h354;
      tfrom[ch] = NEVER; tuntil[ch] = NEVER; slips[ch] = 0;
      lock_cyc[ch] = -1; drop_cyc[ch] = -1;
      exp_q[ch].delete();
    end
    all_cyc = -1;
    err_seen = 3'b000;
    cyc = 0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({o_bitslip, o_locked, o_all_locked, o_slip_cnt, o_align_err}), 0);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic check_drained(input string name);
    for (int ch = 0; ch < 3; ch++)
      chk($sformatf("%s_missing_slips_ch%0d", name, ch), exp_q[ch].size(), 0);
  endtask

  initial begin
    for (int ch = 0; ch < 3; ch++) enc[ch] = 10'h000;
    //           rot       tokens                    tokens-from   run  nslip    lock cycles      all  slip_cnt err
    vecs[0] = mk(0, 0, 0, 10'h354, 10'h354, 10'h354, 0, 0, 0,      100, 0, 0, 0, 17, 17, 17,      18,  12'h000, 3'b000);
    vecs[1] = mk(0, 3, 0, 10'h354, 10'h354, 10'h354, 0, 0, 0,      300, 0, 3, 0, 17, 235, 17,     236, 12'h030, 3'b000);
    vecs[2] = mk(1, 2, 9, 10'h2AB, 10'h154, 10'h0AB, 0, 0, 0,      700, 1, 2, 9, 89, 162, 673,    674, 12'h921, 3'b000);
    vecs[3] = mk(0, 0, 0, 10'h354, 10'h354, 10'h354, 0, 0, 722,    800, 0, 0, 10, 17, 17, 746,    747, 12'h000, 3'b100);
    vecs[4] = mk(0, 0, 0, 10'h0AB, 10'h154, 10'h2AB, 0, 0, 0,      100, 0, 0, 0, 17, 17, 17,      18,  12'h000, 3'b000);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int ch = 0; ch < 3; ch++) begin
        rot[ch]   = int'(vecs[v].rot[ch]);
        tw[ch]    = vecs[v].tw[ch];
        tfrom[ch] = int'(vecs[v].tfrom[ch]);
        for (int j = 0; j < int'(vecs[v].nslip[ch]); j++) exp_q[ch].push_back(W + PER * j);
      end
      repeat (int'(vecs[v].run)) step();
      check_drained($sformatf("vec%0d", v));
      for (int ch = 0; ch < 3; ch++) begin
        chk($sformatf("vec%0d_lock_cycle_ch%0d", v, ch), lock_cyc[ch], int'(vecs[v].lock[ch]));
        chk($sformatf("vec%0d_slip_count_ch%0d", v, ch), slips[ch], int'(vecs[v].nslip[ch]));
      end
      chk($sformatf("vec%0d_all_locked_cycle", v), all_cyc, int'(vecs[v].all_lock));
      chk($sformatf("vec%0d_slip_cnt", v), int'(o_slip_cnt), int'(vecs[v].slip_cnt));
      chk($sformatf("vec%0d_err_seen", v), int'(err_seen), int'(vecs[v].err_seen));
      chk($sformatf("vec%0d_final_err", v), int'(o_align_err), 0);
      chk($sformatf("vec%0d_final_locked", v), int'(o_locked), 7);
    end

    // Enable dropped 20 cycles into the first window, no tokens anywhere.
    do_reset();
    repeat (20) step();
    en = 1'b0;
    repeat (5) step();
    chk("en_low_locked", int'(o_locked), 0);
    chk("en_low_bitslip", int'(o_bitslip), 0);
    repeat (5) step();
    en = 1'b1;
    for (int ch = 0; ch < 3; ch++) exp_q[ch].push_back(30 + W);
    repeat (71) step();
    check_drained("enable");
    chk("enable_slip_cnt", int'(o_slip_cnt), 12'h111);

    // Tokens stop on green after lock.
    do_reset();
    for (int ch = 0; ch < 3; ch++) tfrom[ch] = 0;
    tuntil[1] = 30;
`ifdef TMDS_ALIGN_RELOCK_EN
    exp_q[1].push_back(131 + W);
`endif
    repeat (230) step();
    chk("loss_lock_cycle", lock_cyc[1], 17);
`ifdef TMDS_ALIGN_RELOCK_EN
    chk("loss_drop_cycle", drop_cyc[1], 131);
    chk("loss_slip_cnt_green", int'(o_slip_cnt[7:4]), 1);
`else
    chk("loss_drop_cycle", drop_cyc[1], -1);
    chk("loss_still_locked", int'(o_locked), 7);
`endif
    check_drained("loss");

    // Async reset in a SLIP cycle with nonzero slip_cnt, err and lock.
    do_reset();
    tfrom[0] = 0;
    for (int j = 0; j < 11; j++) begin
      exp_q[1].push_back(W + PER * j);
      exp_q[2].push_back(W + PER * j);
    end
    repeat (867) step();
    check_drained("arst");
    chk("arst_pre_bitslip", int'(o_bitslip), 3'b110);
    chk("arst_pre_slip_cnt", int'(o_slip_cnt), 12'h110);
    chk("arst_pre_err", int'(o_align_err), 3'b110);
    chk("arst_pre_locked", int'(o_locked), 3'b001);
    rst = 1'b1;
    #1;
    chk("arst_bitslip", int'(o_bitslip), 0);
    chk("arst_slip_cnt", int'(o_slip_cnt), 0);
    chk("arst_err", int'(o_align_err), 0);
    chk("arst_locked", int'(o_locked), 0);
    chk("arst_all_locked", int'(o_all_locked), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tmds_align_ctrl.md
# tmds_align_ctrl

Word-alignment controller for the three-channel HDMI receive datapath. It sits between the de-serializer outputs and the decoder and watches each channel's 10-bit encoded word for TMDS control tokens. For each channel it sequences bitslip pulses back into the de-serializer until the word boundary is found, then reports per-channel and aggregate lock. Downstream logic qualifies decoded pixels with `o_all_locked`.

## Interface
- `WINDOW_CYCLES`, 4096: search window per slip position, in pixel clocks; covers more than one full line including blanking.
- `TOKEN_MIN`, 16: control tokens required within one window to declare lock.
- `SLIP_WAIT`, 8: settle cycles after each bitslip pulse before searching again.
- `LOSS_CYCLES`, 65536: token-free cycles in LOCKED that count as loss of lock; used only with the relock feature.
- `i_pixclk` in 1: the only clock; all logic runs on it.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_enable` in 1: level. While low, all channels are held in SEARCH.
- `i_encoded_blue` in 10: channel 0 word from the de-serializer.
- `i_encoded_green` in 10: channel 1 word.
- `i_encoded_red` in 10: channel 2 word.
- `o_bitslip` out 3: per-channel one-cycle bitslip request to the de-serializer. Bit 0 is blue, bit 1 green, bit 2 red.
- `o_locked` out 3: per-channel lock.
- `o_all_locked` out 1: AND of `o_locked`, registered.
- `o_slip_cnt` out 12: per-channel current slip position 0..9, packed as 4 bits per channel: [3:0] blue, [7:4] green, [11:8] red.
- `o_align_err` out 3: per-channel sticky flag. Set when a channel wraps through all 10 positions without locking.

## Operation
- **Token detect.** A word is a token if it equals 0x354, 0x0AB, 0x154 or 0x2AB. Detection is registered (`tok_q`), one per channel.
- **Channel FSMs.** There are three identical, independent FSMs with states SEARCH, SLIP, WAIT and LOCKED.
- **SEARCH**
  - `win_cnt` increments every cycle; `tok_cnt` increments on each `tok_q`.
  - When `tok_cnt` reaches `TOKEN_MIN`, the FSM goes to LOCKED. This takes priority over window expiry in the same cycle.
  - When `win_cnt == WINDOW_CYCLES-1` and the token count is short, the FSM goes to SLIP.
- **SLIP**
  - Lasts exactly one cycle; `o_bitslip[ch]` is 1 only in this state.
  - `slip_cnt` increments. On a slip from 9 it wraps to 0 and `o_align_err[ch]` is set.
  - The FSM then goes to WAIT.
- **WAIT**
  - Counts `SLIP_WAIT` cycles, then returns to SEARCH.
  - `win_cnt` and `tok_cnt` are cleared on entry to SEARCH.
  - `tok_q` is ignored in this state.
- **LOCKED**
  - `o_locked[ch]` is 1.
  - `o_align_err[ch]` is cleared on entry.
  - `slip_cnt` holds.
- **i_enable low.** All FSMs are forced to SEARCH synchronously and the counters are cleared. `slip_cnt` and `o_align_err` hold. No bitslip is issued. When `i_enable` rises, search restarts with a fresh window.
- **Counter widths.** Each counter is `$clog2` of its parameter; none of them may overflow.

## Timing
- **Reset values.** All outputs are 0; FSMs are in SEARCH; all counters are 0.
- **Lock latency.** Tokens are presented every cycle starting on the first SEARCH cycle (cycle 0). `o_locked` rises at cycle `TOKEN_MIN+1`, and `o_all_locked` rises one cycle after the last channel locks.
- **Slip latency.** A channel that sees no tokens asserts `o_bitslip` on cycle `WINDOW_CYCLES` after SEARCH entry. The next SEARCH begins `SLIP_WAIT+1` cycles after the pulse. The slip period is therefore `WINDOW_CYCLES+1+SLIP_WAIT` cycles.
- **Spacing and skew.** Bitslip pulses on one channel are never adjacent. Channels slip independently, with no cross-channel alignment or skew handling.
- **Reset mid-operation.** `i_rst` asserted during SLIP deasserts `o_bitslip` immediately, because the reset is asynchronous.

## Configuration
- **Macro:** `TMDS_ALIGN_RELOCK_EN`.
- **Defined:** in LOCKED, a token-free run counter is cleared on each `tok_q`. Reaching `LOSS_CYCLES` sends the channel back to SEARCH; `o_locked` falls on the next cycle and `slip_cnt` is kept.
- **Undefined:** LOCKED is left only on `i_rst` or `i_enable` low. `LOSS_CYCLES` is unused and no loss counter is synthesised.

## Test plan
- **Aligned tokens:** 0x354 every cycle on all channels, `WINDOW_CYCLES`=64, `TOKEN_MIN`=16 → `o_locked`=3'b111 at cycle 17, `o_all_locked` at cycle 18, `o_bitslip` never asserted, `o_slip_cnt`=0.
- **Misaligned by 3:**
  - Stimulus: green carries tokens rotated by 3 bits; the bench model de-rotates by 1 per bitslip.
  - Required: exactly 3 green bitslip pulses, each one cycle wide and spaced 73 cycles apart; then green locks with `o_slip_cnt[7:4]`=3.
- **No tokens ever (red):** 10 slips → `o_slip_cnt[11:8]` wraps 9→0 and `o_align_err[2]`=1. Tokens are then enabled → red locks and `o_align_err[2]` clears.
- **Enable toggle:** `i_enable` is dropped 20 cycles into a window → no bitslip, FSMs in SEARCH. Re-enable → first slip exactly `WINDOW_CYCLES` cycles later.
- **Loss of lock:** with `TMDS_ALIGN_RELOCK_EN` and `LOSS_CYCLES`=100, stop tokens after lock → `o_locked` falls 101 cycles later. Without the macro, `o_locked` stays 1.
- **Async reset mid-SLIP:** assert `i_rst` in the SLIP cycle → `o_bitslip`, `o_slip_cnt`, `o_align_err` and `o_locked` are 0 before the next clock edge.
